uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Parametrised next-generation UART receiver: configurable data width, parity mode and stop bits; oversampled start/bit detection with 3-sample majority vote.
- Received words and per-word error flags go into an internal first-word-fall-through FIFO; sticky overrun flag.
- Sits between the board rx pin and a consumer on the same clock; pairs with the existing uart_tx.

Parameters:
- INPUT_CLK, 100_000_000, clk frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- DATA_BITS, 8, data bits per frame, legal 5..9.
- STOP_BITS, 1, stop bits checked, legal 1 or 2.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- OVERSAMPLE, 16, ticks per bit, even, >= 8.
- FIFO_DEPTH, 16, FIFO entries, power of two, >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- rd_en  in  1  pop head entry; ignored when empty.
- rd_data  out  DATA_BITS  head entry data; 0 when empty.
- rd_parity_err  out  1  head entry parity error; 0 when empty or PARITY_MODE = 0.
- rd_frame_err  out  1  head entry stop-bit error; 0 when empty.
- rd_break  out  1  head entry is a break (see Optional Feature); 0 when empty.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- level  out  $clog2(FIFO_DEPTH)+1  entries held.
- overrun  out  1  sticky: a completed frame was dropped because the FIFO was full.
- overrun_clr  in  1  clears overrun.
- rx_busy  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: empty = 1, full = 0, level = 0, overrun = 0, rx_busy = 0, all rd_* = 0. The 2-flop rx synchroniser presets to 1.
- Reset mid-frame abandons the frame and clears the FIFO.
- Tick generator: DIV = max(1, floor(INPUT_CLK / (BAUD_RATE * OVERSAMPLE))). One-cycle tick every DIV clocks. The counter free-runs and restarts on start detection. Default: DIV = 54, bit = 864 clk.
- Sampling: the mid-bit value is the majority of synchronised rx at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within each bit.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: synced rx 1 -> 0 transition moves to START and raises rx_busy. A low level without a preceding high does not start a frame.
- START: majority = 1 is a glitch; return to IDLE with no entry pushed. Majority = 0 -> DATA.
- DATA: DATA_BITS bits, LSB first, shifted in at each bit's majority point. Then -> PARITY if PARITY_MODE != 0, else -> STOP.
- PARITY: expected bit = XOR(data) for even, ~XOR(data) for odd. Mismatch sets the entry's parity_err.
- STOP: each of STOP_BITS stop bits must sample 1; any 0 sets frame_err.
- Push: at the majority point of the last stop bit, push {data, parity_err, frame_err, break}. Then go to IDLE, or to WAIT_HIGH if the last stop sample was 0. rx_busy drops the same cycle.
- WAIT_HIGH: stay until synced rx = 1, then go to IDLE.
- Back-to-back frames: a start edge arriving one half-bit after the stop midpoint is accepted.
- FIFO is FWFT: rd_* show the head entry whenever !empty. rd_en pops at the clock edge; level updates next cycle.
- Push and pop in the same cycle: both occur; level unchanged. This holds when full, so no overrun.
- Push while full without rd_en: the frame is dropped and overrun is set next cycle.
- overrun_clr and a new overrun in the same cycle: set wins.
- Pop while empty: no effect; level never underflows.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined: a frame is a break when all data bits, the parity bit (if any) and the first stop bit all sample 0.
  - Push one entry: data = 0, rd_break = 1, rd_frame_err = 1, rd_parity_err = 0.
  - Then go to WAIT_HIGH; no further entries are pushed until rx returns high.
- Not defined: rd_break is tied to 0. The same line condition pushes a normal entry with data = 0, frame_err = 1 and parity_err as computed, then goes to WAIT_HIGH.

Test Plan:
- Defaults, PARITY_MODE = 1: send 0x3D, 0xC3, 0xAA, 0x55 with correct parity -> four entries in order, all flags 0; level reaches 4; popping empties the FIFO in FIFO order.
- PARITY_MODE = 2: send 0xA5 with an even parity bit -> entry 0xA5, rd_parity_err = 1.
- Stop bit driven 0 for one bit time after 0x7E -> rd_frame_err = 1, data 0x7E. No new frame starts until rx goes high.
- A 200 ns low pulse on idle rx -> no entry; rx_busy pulses and then returns to 0.
- FIFO_DEPTH = 4, no reads, send 5 frames -> full = 1, level = 4, overrun = 1, entries 1..4 kept. overrun_clr -> overrun = 0.
- DATA_BITS = 9, STOP_BITS = 2: send 0x1FF.
  - Then hold rx low for 12 bit times -> with UART_RX_BREAK_DETECT_EN: entry 0x1FF, then one break entry with rd_break = 1.
  - Without the macro: entry 0x1FF, then one entry with data 0 and rd_frame_err = 1.
  - Separately, reset asserted mid-frame -> empty = 1 and no entry pushed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver (3-sample majority per bit) feeding a
// first-word-fall-through FIFO of {data, parity_err, frame_err, break} entries.
// Optional feature macro: UART_RX_BREAK_DETECT_EN (break frames reported as one
// dedicated entry with rd_break = 1).
module uart_rx_fifo #(
  parameter int unsigned INPUT_CLK   = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx,
  input  logic                        rd_en,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        rd_parity_err,
  output logic                        rd_frame_err,
  output logic                        rd_break,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overrun,
  input  logic                        overrun_clr,
  output logic                        rx_busy
);

  localparam int unsigned DIV_RAW = INPUT_CLK / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SMP_W   = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W   = $clog2(DATA_BITS);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned S_LO    = OVERSAMPLE / 2 - 1;
  localparam int unsigned S_MID   = OVERSAMPLE / 2;
  localparam int unsigned S_HI    = OVERSAMPLE / 2 + 1;

`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 brk;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  // synchroniser and edge history
  logic rx_meta, rx_s, rx_prev;
  // tick generator and per-bit sample phase
  logic [CNT_W-1:0] div_cnt;
  logic [SMP_W-1:0] smp_cnt;
  logic             smp_a, smp_b;
  logic             tick, mid_pt, maj, start_det;
  // receiver state
  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 all_zero, par_err, frm_err;
  logic                 exp_par, frm_nxt, last_stop, brk_now;
  logic                 push_vld;
  entry_t               push_ent;
  // FIFO
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [LVL_W-1:0] count, count_nxt, remain;
  logic             pop, push, drop, is_full;
  entry_t           head_nxt;

  // Two-flop synchroniser for the asynchronous rx pin, idle-high preset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_det = (state == S_IDLE) && rx_prev && !rx_s;
  assign tick      = (div_cnt == CNT_W'(DIV - 1));
  assign mid_pt    = tick && (smp_cnt == SMP_W'(S_HI));
  assign maj       = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

  // Free-running oversample divider, realigned to each start edge.
  always_ff @(posedge clk) begin
    if (reset || start_det || tick) div_cnt <= '0;
    else                            div_cnt <= div_cnt + CNT_W'(1);
  end

  // Tick index within the bit; capture the two samples preceding the vote.
  always_ff @(posedge clk) begin
    if (reset || start_det) begin
      smp_cnt <= '0;
      smp_a   <= 1'b1;
      smp_b   <= 1'b1;
    end else if (tick) begin
      smp_cnt <= (smp_cnt == SMP_W'(OVERSAMPLE - 1)) ? '0 : smp_cnt + SMP_W'(1);
      if (smp_cnt == SMP_W'(S_LO))  smp_a <= rx_s;
      if (smp_cnt == SMP_W'(S_MID)) smp_b <= rx_s;
    end
  end

  // Frame checks evaluated at the majority point.
  always_comb begin
    exp_par   = (^shreg) ^ (PARITY_MODE == 2);
    frm_nxt   = frm_err | ~maj;
    last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    brk_now   = BRK_EN && all_zero && !maj && (stop_cnt == 1'b0);
  end

  // Receiver FSM: start qualification, data/parity/stop sampling, entry push.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rx_busy  <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      all_zero <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      push_vld <= 1'b0;
      push_ent <= '0;
    end else begin
      push_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_det) begin
            state   <= S_START;
            rx_busy <= 1'b1;
          end
        end
        S_START: begin
          if (mid_pt) begin
            if (maj) begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              state    <= S_DATA;
              bit_cnt  <= '0;
              stop_cnt <= 1'b0;
              all_zero <= 1'b1;
              par_err  <= 1'b0;
              frm_err  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (mid_pt) begin
            shreg    <= {maj, shreg[DATA_BITS-1:1]};
            all_zero <= all_zero & ~maj;
            if (bit_cnt == BIT_W'(DATA_BITS - 1))
              state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            else
              bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        S_PARITY: begin
          if (mid_pt) begin
            par_err  <= (maj != exp_par);
            all_zero <= all_zero & ~maj;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (mid_pt) begin
            if (brk_now) begin
              push_vld            <= 1'b1;
              push_ent.data       <= '0;
              push_ent.parity_err <= 1'b0;
              push_ent.frame_err  <= 1'b1;
              push_ent.brk        <= 1'b1;
              state               <= S_WAIT_HIGH;
              rx_busy             <= 1'b0;
            end else if (last_stop) begin
              push_vld            <= 1'b1;
              push_ent.data       <= shreg;
              push_ent.parity_err <= par_err;
              push_ent.frame_err  <= frm_nxt;
              push_ent.brk        <= 1'b0;
              state               <= maj ? S_IDLE : S_WAIT_HIGH;
              rx_busy             <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
              frm_err  <= frm_nxt;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // FIFO next-state: push/pop arbitration and the head entry after this edge.
  always_comb begin
    pop        = rd_en && (count != '0);
    is_full    = (count == LVL_W'(FIFO_DEPTH));
    push       = push_vld && (!is_full || pop);
    drop       = push_vld && is_full && !pop;
    count_nxt  = count + LVL_W'(push) - LVL_W'(pop);
    remain     = count - LVL_W'(pop);
    rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    head_nxt   = '0;
    if (remain == '0) begin
      if (push) head_nxt = push_ent;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // FIFO storage, written without reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  // FIFO pointers, occupancy, registered head outputs and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      empty         <= 1'b1;
      full          <= 1'b0;
      rd_data       <= '0;
      rd_parity_err <= 1'b0;
      rd_frame_err  <= 1'b0;
      rd_break      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr        <= rd_ptr_nxt;
      count         <= count_nxt;
      empty         <= (count_nxt == '0);
      full          <= (count_nxt == LVL_W'(FIFO_DEPTH));
      rd_data       <= head_nxt.data;
      rd_parity_err <= head_nxt.parity_err;
      rd_frame_err  <= head_nxt.frame_err;
      rd_break      <= BRK_EN ? head_nxt.brk : 1'b0;
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  assign level = count;

endmodule
